// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared constants for the instruction fetch stage
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [0:0]  S_FETCH          = 1'b0;
  localparam logic [0:0]  S_HOLD           = 1'b1;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_next.sv
// ============================================================================
// fetch_pc_next : next-PC select (hold / +4 / word-aligned redirect) and
//                 misaligned-target detect
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        advance,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_next,
  output logic        misalign
);

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_target & ~32'h3;
    end else if (advance) begin
      pc_next = pc + PC_INC;
    end
  end

  assign misalign = redirect_valid && (redirect_target[1:0] != 2'b00);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC owner, IR latch and valid/ready hand-off to decode
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IM_AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] inst_in,
  output logic [31:0] ir_out,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_pc4,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        misalign_err,
  output logic [31:0] inst_count
);

  logic [0:0]  state;
  logic [31:0] pc_next;
  logic        misalign;
  logic        fetch_now;

  // The IM index must fit inside the byte-addressed 32-bit PC.
  if (IM_AW < 1 || IM_AW > 30) begin : g_im_aw_out_of_range
  end

  assign fetch_now = (state == S_FETCH) && !redirect_valid;

  fetch_pc_next u_pc_next (
    .pc              (pc_out),
    .advance         (fetch_now),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_next         (pc_next),
    .misalign        (misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_FETCH;
      pc_out       <= RESET_PC;
      ir_out       <= 32'h0;
      ir_pc        <= 32'h0;
      misalign_err <= 1'b0;
      inst_count   <= 32'h0;
    end else begin
      pc_out <= pc_next;
      if (misalign) begin
        misalign_err <= 1'b1;
      end
      case (state)
        S_FETCH: begin
          // A redirect discards the word currently on the IM bus.
          if (fetch_now) begin
            ir_out <= inst_in;
            ir_pc  <= pc_out;
            state  <= S_HOLD;
          end
        end
        default: begin
          if (inst_ready) begin
            inst_count <= inst_count + 32'd1;
            state      <= S_FETCH;
          end else if (redirect_valid) begin
            state <= S_FETCH;
          end
        end
      endcase
    end
  end

  assign inst_valid = (state == S_HOLD);
  assign ir_pc4     = ir_pc + PC_INC;

endmodule

`default_nettype wire
